timer_request_scheduler: RTL and testbench

- Shares one interval-timer slave (16-bit Avalon-MM register map) among N hardware requesters that each need a one-shot delay.
- Round-robin arbiter plus Avalon-MM master FSM:
  - programs the period;
  - starts the timer in one-shot mode with interrupt enabled;
  - waits for the timer irq;
  - clears the timeout status;
  - returns a done pulse to the granted requester.
- Sits between requester logic and the timer slave's s1 port.

---
 rtl/timer_request_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_timer_request_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : timer_request_scheduler
// Description : Shares one Avalon-MM interval timer among NUM_REQ requesters
//               that each need a one-shot delay. A round-robin arbiter picks
//               a requester. A write-only Avalon-MM master then programs the
//               period, starts the timer one-shot with its interrupt enabled,
//               waits for the irq, clears the timeout status and pulses done
//               back to the granted requester.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               req             - per-requester request level
//               req_delay       - per-requester 32-bit delay, slice i at 32*i
//               done            - one-cycle pulse to the served requester
//               busy            - high from grant through the done cycle
//               grant_idx       - current / last granted requester
//               avm_*           - Avalon-MM master to the timer s1 port
//               timer_irq       - timer interrupt level
// Revision    : 1.0 - initial release
// ============================================================================
module timer_request_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  req_delay,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_idx,
    output logic [2:0]             avm_address,
    output logic                   avm_write,
    output logic [15:0]            avm_writedata,
    input  logic                   avm_waitrequest,
    input  logic                   timer_irq
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [2:0]  C_ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  C_ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  C_ADDR_PERIODL = 3'd2;
    localparam logic [2:0]  C_ADDR_PERIODH = 3'd3;
    // Control word: ITO=1, CONT=0, START=1
    localparam logic [15:0] C_CTRL_START   = 16'h0005;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT    = 3'd1,
        S_WR_PL    = 3'd2,
        S_WR_PH    = 3'd3,
        S_WR_CTL   = 3'd4,
        S_WAIT_IRQ = 3'd5,
        S_WR_STAT  = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_delay;
    logic [31:0]         w_delay_nxt;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    w_rr_nxt;
    logic [IDX_W-1:0]    w_grant_nxt;
    logic                w_sel_vld;
    logic [IDX_W-1:0]    w_sel_idx;
    logic [31:0]         w_sel_delay;
    logic [NUM_REQ-1:0]  w_done_nxt;
    logic                w_busy_nxt;
    logic                w_write_nxt;
    logic [2:0]          w_addr_nxt;
    logic [15:0]         w_data_nxt;

    // (base + k) modulo NUM_REQ, valid for base < NUM_REQ and k < NUM_REQ
    function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Round-robin pick: scanning k downwards lets the smallest offset from
    // the pointer overwrite any larger one, so the first requester at or
    // above r_rr_ptr wins.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[f_wrap(r_rr_ptr, k)]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = f_wrap(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_sel_delay = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel_idx == IDX_W'(i)) begin
                w_sel_delay = req_delay[32*i +: 32];
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_delay_nxt = r_delay;
        w_grant_nxt = grant_idx;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_sel_vld) begin
                    w_grant_nxt = w_sel_idx;
                    w_delay_nxt = w_sel_delay;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT:    w_state_nxt = (r_delay == 32'd0) ? S_DONE : S_WR_PL;
            S_WR_PL:    if (!avm_waitrequest) w_state_nxt = S_WR_PH;
            S_WR_PH:    if (!avm_waitrequest) w_state_nxt = S_WR_CTL;
            S_WR_CTL:   if (!avm_waitrequest) w_state_nxt = S_WAIT_IRQ;
            // A stale irq already high here is accepted by design.
            S_WAIT_IRQ: if (timer_irq) w_state_nxt = S_WR_STAT;
            S_WR_STAT:  if (!avm_waitrequest) w_state_nxt = S_DONE;
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_rr_nxt    = (grant_idx == C_LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state, so each write's
    // address/data appear together with the strobe and stay put while the
    // FSM holds in a write state under waitrequest.
    always_comb begin
        w_write_nxt = 1'b0;
        w_addr_nxt  = 3'd0;
        w_data_nxt  = 16'd0;
        case (w_state_nxt)
            S_WR_PL: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = C_ADDR_PERIODL;
                w_data_nxt  = w_delay_nxt[15:0];
            end
            S_WR_PH: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = C_ADDR_PERIODH;
                w_data_nxt  = w_delay_nxt[31:16];
            end
            S_WR_CTL: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = C_ADDR_CONTROL;
                w_data_nxt  = C_CTRL_START;
            end
            S_WR_STAT: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = C_ADDR_STATUS;
                w_data_nxt  = 16'h0000;
            end
            default: ;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
        for (int i = 0; i < NUM_REQ; i++) begin
            w_done_nxt[i] = (w_state_nxt == S_DONE) && (w_grant_nxt == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_delay       <= '0;
            r_rr_ptr      <= '0;
            grant_idx     <= '0;
            done          <= '0;
            busy          <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= 3'd0;
            avm_writedata <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_delay       <= w_delay_nxt;
            r_rr_ptr      <= w_rr_nxt;
            grant_idx     <= w_grant_nxt;
            done          <= w_done_nxt;
            busy          <= w_busy_nxt;
            avm_write     <= w_write_nxt;
            avm_address   <= w_addr_nxt;
            avm_writedata <= w_data_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_request_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_timer_request_scheduler
// Description : Self-checking bench for timer_request_scheduler. Contains a
//               one-shot timer slave model, a waitrequest generator and a
//               transaction-level reference model (round-robin choice,
//               expected write list per service, done/busy protocol).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_request_scheduler;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    // Timer model fires after min(period, TM_CAP)+1 clocks to keep runs short
    localparam int TM_CAP  = 200;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req = '0;
    logic [32*NUM_REQ-1:0] req_delay = '0;
    logic [NUM_REQ-1:0]    done;
    logic                  busy;
    logic [IDX_W-1:0]      grant_idx;
    logic [2:0]            avm_address;
    logic                  avm_write;
    logic [15:0]           avm_writedata;
    logic                  avm_waitrequest = 1'b0;
    logic                  timer_irq;

    timer_request_scheduler #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_delay       (req_delay),
        .done            (done),
        .busy            (busy),
        .grant_idx       (grant_idx),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .timer_irq       (timer_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timer slave model (not reset by the scheduler) -------
    logic        tm_irq = 1'b0;
    logic        tm_run = 1'b0;
    logic [31:0] tm_period = '0;
    logic [31:0] tm_cnt = '0;
    assign timer_irq = tm_irq;

    always @(posedge clk) begin
        if (tm_run) begin
            if (tm_cnt == 0) begin
                tm_irq <= 1'b1;
                tm_run <= 1'b0;
            end else begin
                tm_cnt <= tm_cnt - 1;
            end
        end
        if (avm_write && !avm_waitrequest) begin
            case (avm_address)
                3'd0: tm_irq <= 1'b0;
                3'd1: if (avm_writedata[2]) begin
                          tm_run <= 1'b1;
                          tm_cnt <= ((tm_period > TM_CAP) ? TM_CAP : tm_period) - 1;
                      end
                3'd2: begin tm_period[15:0]  <= avm_writedata; tm_run <= 1'b0; end
                3'd3: begin tm_period[31:16] <= avm_writedata; tm_run <= 1'b0; end
                default: ;
            endcase
        end
    end

    // ---------------- waitrequest generator + reference model --------------
    int                 stall_mode = 0;   // >=0: fixed stall per write, -1: random
    int                 wcnt = 0;
    int                 m_rr = 0;
    int                 m_idx = 0;
    int                 m_e;
    logic [31:0]        m_d;
    logic [NUM_REQ-1:0] m_prev_req = '0;
    logic               m_prev_busy = 1'b0;
    logic [NUM_REQ-1:0] m_prev_done = '0;
    logic               m_prev_pend = 1'b0;
    logic [2:0]         m_prev_addr = '0;
    logic [15:0]        m_prev_data = '0;
    logic [18:0]        m_exp_q[$];
    logic [18:0]        m_w;
    int                 n_wr_cycles = 0;
    int                 n_serv = 0;

    always @(negedge clk) begin
        if (reset) begin
            m_rr = 0;
            m_exp_q.delete();
            m_prev_busy = 1'b0;
            m_prev_done = '0;
            m_prev_pend = 1'b0;
            wcnt = 0;
            avm_waitrequest = 1'b0;
        end else begin
            // waitrequest for the write (if any) presented in this cycle
            if (avm_write) begin
                if (stall_mode < 0) begin
                    avm_waitrequest = ($urandom_range(0, 2) == 0);
                end else if (wcnt < stall_mode) begin
                    avm_waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    wcnt = 0;
                end
            end else begin
                avm_waitrequest = 1'b0;
            end

            if (m_prev_pend)
                check("wr_hold", {avm_write, avm_address, avm_writedata},
                      {1'b1, m_prev_addr, m_prev_data});

            if (busy && !m_prev_busy) begin
                m_e = -1;
                for (int k = NUM_REQ - 1; k >= 0; k--)
                    if (m_prev_req[(m_rr + k) % NUM_REQ]) m_e = (m_rr + k) % NUM_REQ;
                check("rr_grant_idx", 64'(grant_idx), 64'(m_e));
                check("stale_expected_writes", 64'(m_exp_q.size()), 0);
                m_exp_q.delete();
                m_idx = int'(grant_idx);
                m_d = req_delay[32*m_idx +: 32];
                if (m_d != 0) begin
                    m_exp_q.push_back({3'd2, m_d[15:0]});
                    m_exp_q.push_back({3'd3, m_d[31:16]});
                    m_exp_q.push_back({3'd1, 16'h0005});
                    m_exp_q.push_back({3'd0, 16'h0000});
                end
            end

            if (avm_write) n_wr_cycles++;
            if (avm_write && !avm_waitrequest) begin
                check("write_expected", 64'(m_exp_q.size() != 0), 1);
                if (m_exp_q.size() != 0) begin
                    m_w = m_exp_q.pop_front();
                    check("write_addr_data", {avm_address, avm_writedata}, m_w);
                end
            end

            if (done != '0) begin
                check("done_vec", done, 64'(1) << m_idx);
                check("done_busy", busy, 1);
                check("done_writes_left", 64'(m_exp_q.size()), 0);
                m_rr = (m_idx + 1) % NUM_REQ;
                n_serv++;
            end
            if (m_prev_done != '0) begin
                check("done_one_cycle", done, 0);
                check("busy_drop_after_done", busy, 0);
            end

            m_prev_pend = avm_write && avm_waitrequest;
            m_prev_addr = avm_address;
            m_prev_data = avm_writedata;
            m_prev_req  = req;
            m_prev_busy = busy;
            m_prev_done = done;
        end
    end

    // ---------------- directed + table + random stimulus -------------------
    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic [31:0]        delay;
        int                 stall;
        int                 exp_idx;
        int                 exp_wr_cycles;
        int                 exp_lat;       // cycles from first busy cycle to done
    } vec_t;

    vec_t vt[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant_idx"}, grant_idx, 0);
        check({tag, "_avm_write"}, avm_write, 0);
        check({tag, "_avm_address"}, avm_address, 0);
        check({tag, "_avm_writedata"}, avm_writedata, 0);
    endtask

    task automatic wait_busy(input string tag, input int bound);
        int n;
        n = 0;
        while (!busy && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_busy_seen"}, busy, 1);
    endtask

    task automatic wait_done(input string tag, input int bound, output int lat);
        lat = 0;
        while (done == '0 && lat < bound) begin
            tick();
            lat++;
        end
        check({tag, "_done_seen"}, 64'(done != '0), 1);
    endtask

    int lat;
    int w0;
    int s0;

    initial begin
        vt[0] = '{4'b0001, 32'd10,          0, 0,  4,  16};
        vt[1] = '{4'b0100, 32'd0,           0, 2,  0,   1};
        vt[2] = '{4'b0010, 32'h0001_2345,   3, 1, 16, 218};
        vt[3] = '{4'b1000, 32'd3,           0, 3,  4,   9};
        vt[4] = '{4'b1001, 32'd4,           0, 0,  4,  10};
        vt[5] = '{4'b1000, 32'd2,           0, 3,  4,   8};

        reset = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // single-request vectors
        for (int v = 0; v < 6; v++) begin
            stall_mode = vt[v].stall;
            for (int i = 0; i < NUM_REQ; i++) req_delay[32*i +: 32] = vt[v].delay;
            w0  = n_wr_cycles;
            req = vt[v].req;
            wait_busy($sformatf("vec%0d", v), 20);
            check($sformatf("vec%0d_grant_idx", v), grant_idx, vt[v].exp_idx);
            wait_done($sformatf("vec%0d", v), 1000, lat);
            req = '0;
            check($sformatf("vec%0d_latency", v), 64'(lat), 64'(vt[v].exp_lat));
            check($sformatf("vec%0d_done", v), done, 64'(1) << vt[v].exp_idx);
            check($sformatf("vec%0d_write_cycles", v), 64'(n_wr_cycles - w0),
                  64'(vt[v].exp_wr_cycles));
            tick();
            check($sformatf("vec%0d_busy_low", v), busy, 0);
        end

        // round-robin with all requests held
        stall_mode = 0;
        for (int i = 0; i < NUM_REQ; i++) req_delay[32*i +: 32] = 32'(5 + i);
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            tick();
            wait_done($sformatf("rr%0d", s), 200, lat);
            check($sformatf("rr%0d_done", s), done, 64'(1) << (s % NUM_REQ));
            check($sformatf("rr%0d_grant_idx", s), grant_idx, 64'(s % NUM_REQ));
        end
        req = '0;
        tick();
        tick();

        // reset while waiting for irq; pointer is 1 so index 1 wins first
        for (int i = 0; i < NUM_REQ; i++) req_delay[32*i +: 32] = 32'd50;
        req = 4'b0011;
        wait_busy("rst_mid", 20);
        check("rst_mid_first_grant", grant_idx, 1);
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("rst_mid");
        wait_busy("rst_mid_regrant", 20);
        check("rst_mid_regrant_idx", grant_idx, 0);
        wait_done("rst_mid_regrant", 500, lat);
        check("rst_mid_regrant_done", done, 4'b0001);
        req = '0;
        tick();
        tick();

        // randomized traffic checked by the reference model
        stall_mode = -1;
        s0 = n_serv;
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    req_delay[32*i +: 32] = ($urandom_range(0, 4) == 0) ? 32'd0
                                            : 32'($urandom_range(1, 20));
                    req[i] = 1'b1;
                end
            end
        end
        for (int c = 0; c < 3000 && (req != '0 || busy); c++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) if (done[i]) req[i] = 1'b0;
        end
        check("random_drained", {req, busy}, 0);
        check("random_services_seen", 64'(n_serv > s0 + 20), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
